// File: rtl/multi_cycle_control_unit.sv
// multi_cycle_control_unit: IF/ID/EXE/MEM/WB sequencer driving the multi-cycle datapath controls.
// Define CU_HALT_EN to make opcode 111111 park the FSM in HLT until Reset.
module multi_cycle_control_unit (
  input  logic       CLK,
  input  logic       Reset,
  input  logic [5:0] op,
  input  logic       zero,
  output logic       PCWre,
  output logic       IRWre,
  output logic       RegWre,
  output logic       mRD,
  output logic       mWR,
  output logic       ALUSrcB,
  output logic       DBDataSrc,
  output logic       WrRegDSrc,
  output logic       ExtSel,
  output logic [1:0] RegDst,
  output logic [1:0] PCSrc,
  output logic [2:0] ALUOp,
  output logic [3:0] state
);
  typedef enum logic [3:0] {
    S_IF     = 4'b0000,
    S_ID     = 4'b0001,
    S_EXE_LS = 4'b0010,
    S_MEM    = 4'b0011,
    S_WB_LD  = 4'b0100,
    S_EXE_BR = 4'b0101,
    S_EXE_AL = 4'b0110,
    S_WB_AL  = 4'b0111,
    S_HLT    = 4'b1000
  } state_t;
  localparam logic [5:0] OP_ADD = 6'b000000, OP_SUB = 6'b000001, OP_ADDIU = 6'b000010;
  localparam logic [5:0] OP_AND = 6'b010000, OP_ANDI = 6'b010001, OP_ORI = 6'b010010, OP_SLTI = 6'b011011;
  localparam logic [5:0] OP_SW = 6'b110000, OP_LW = 6'b110001, OP_BEQ = 6'b110100, OP_BNE = 6'b110101;
  localparam logic [5:0] OP_J = 6'b111000, OP_JR = 6'b111001, OP_JAL = 6'b111010, OP_HALT = 6'b111111;
  state_t r_state, w_next;
  logic w_add, w_sub, w_addiu, w_and, w_andi, w_ori, w_slti, w_sw, w_lw, w_beq, w_bne, w_j, w_jr, w_jal;
  logic w_alu, w_br, w_ls, w_jmp, w_halt, w_taken;
  assign w_add   = op == OP_ADD;
  assign w_sub   = op == OP_SUB;
  assign w_addiu = op == OP_ADDIU;
  assign w_and   = op == OP_AND;
  assign w_andi  = op == OP_ANDI;
  assign w_ori   = op == OP_ORI;
  assign w_slti  = op == OP_SLTI;
  assign w_sw    = op == OP_SW;
  assign w_lw    = op == OP_LW;
  assign w_beq   = op == OP_BEQ;
  assign w_bne   = op == OP_BNE;
  assign w_j     = op == OP_J;
  assign w_jr    = op == OP_JR;
  assign w_jal   = op == OP_JAL;
`ifdef CU_HALT_EN
  assign w_halt  = op == OP_HALT;
`else
  assign w_halt  = 1'b0;
`endif
  assign w_alu = w_add | w_sub | w_addiu | w_and | w_andi | w_ori | w_slti;
  assign w_br  = w_beq | w_bne;
  assign w_ls  = w_sw | w_lw;
  assign w_jmp = w_j | w_jr | w_jal;
  always_comb begin
    w_next = S_IF;
    case (r_state)
      S_IF:     w_next = S_ID;
      S_ID:     w_next = w_jmp ? S_IF : w_br ? S_EXE_BR : w_ls ? S_EXE_LS : w_alu ? S_EXE_AL : w_halt ? S_HLT : S_IF;
      S_EXE_AL: w_next = S_WB_AL;
      S_EXE_LS: w_next = S_MEM;
      S_MEM:    w_next = w_lw ? S_WB_LD : S_IF;
`ifdef CU_HALT_EN
      S_HLT:    w_next = S_HLT;
`endif
      default:  w_next = S_IF;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (Reset) r_state <= S_IF;
    else       r_state <= w_next;
  end
  // Unknown opcodes finish in ID like a jump, so every instruction gets exactly one PCWre.
  assign PCWre  = (r_state == S_ID && !(w_br || w_ls || w_alu || w_halt)) || r_state == S_EXE_BR ||
                  (r_state == S_MEM && w_sw) || r_state == S_WB_AL || r_state == S_WB_LD;
  assign w_taken = r_state == S_EXE_BR && ((w_beq && zero) || (w_bne && !zero));
  assign PCSrc  = !PCWre ? 2'b00 : (w_j || w_jal) ? 2'b11 : w_jr ? 2'b10 : w_taken ? 2'b01 : 2'b00;
  assign IRWre  = r_state == S_IF;
  assign RegWre = r_state == S_WB_AL || r_state == S_WB_LD || (r_state == S_ID && w_jal);
  assign mWR    = r_state == S_MEM && w_sw;
  assign mRD    = r_state == S_MEM && w_lw;
  assign ExtSel    = w_addiu | w_slti | w_lw | w_sw | w_beq | w_bne;
  assign ALUSrcB   = w_addiu | w_andi | w_ori | w_slti | w_lw | w_sw;
  assign ALUOp     = (w_sub || w_br) ? 3'b001 : w_slti ? 3'b010 : w_ori ? 3'b011 : (w_and || w_andi) ? 3'b100 : 3'b000;
  assign RegDst    = (w_add || w_sub || w_and) ? 2'b10 : w_jal ? 2'b00 : 2'b01;
  assign DBDataSrc = w_lw;
  assign WrRegDSrc = !w_jal;
  assign state     = r_state;
endmodule

// File: doc/multi_cycle_control_unit.md
# multi_cycle_control_unit

Sequencing FSM for the multi-cycle CPU datapath. It takes the opcode held in the instruction register and the ALU zero flag, and steps each instruction through IF/ID/EXE/MEM/WB. Each cycle it drives every datapath select and write enable, including `ExtSel` for the 16-bit immediate extender. It sits between the IR and the datapath: PC, register file, ALU, data memory and the extender.

## Interface
Parameters:
- none (opcode map fixed below)

Ports:
- `CLK`  in  1  system clock; all state updates on the rising edge
- `Reset`  in  1  synchronous, active-high; forces state to IF
- `op`  in  6  opcode from IR, stable from ID until the instruction ends
- `zero`  in  1  ALU zero flag, valid in EXE_BR
- `PCWre`  out  1  PC write enable
- `IRWre`  out  1  IR load enable
- `RegWre`  out  1  register-file write enable
- `mRD`  out  1  data-memory read
- `mWR`  out  1  data-memory write
- `ALUSrcB`  out  1  0 = rt, 1 = extended immediate
- `DBDataSrc`  out  1  0 = ALU result, 1 = memory data
- `WrRegDSrc`  out  1  0 = PC+4 (jal), 1 = DB
- `ExtSel`  out  1  1 = sign-extend, 0 = zero-extend
- `RegDst`  out  2  00 = $31, 01 = rt, 10 = rd
- `PCSrc`  out  2  00 = PC+4, 01 = branch target, 10 = rs (jr), 11 = jump target
- `ALUOp`  out  3  000 = add, 001 = sub, 010 = slt (signed), 011 = or, 100 = and
- `state`  out  4  current state encoding, for debug

## Operation
Opcodes:
- add 000000, sub 000001, addiu 000010
- and 010000, andi 010001, ori 010010, slti 011011
- sw 110000, lw 110001, beq 110100, bne 110101
- j 111000, jr 111001, jal 111010, halt 111111

State encodings:
- IF 0000, ID 0001, EXE_AL 0110, WB_AL 0111, EXE_BR 0101, EXE_LS 0010, MEM 0011, WB_LD 0100, HLT 1000

Transitions:
- IF → ID.
- ID →
  - j/jr/jal: IF
  - beq/bne: EXE_BR
  - sw/lw: EXE_LS
  - add/sub/addiu/and/andi/ori/slti: EXE_AL
  - halt: HLT (if enabled)
  - any other opcode: IF, treated as NOP.
- EXE_AL → WB_AL → IF.
- EXE_BR → IF.
- EXE_LS → MEM.
- MEM: sw → IF; lw → WB_LD → IF.

Static decode (function of `op` only, valid in every state):
- `ExtSel` = 1 for addiu, slti, lw, sw, beq, bne; 0 otherwise. andi and ori zero-extend.
- `ALUSrcB` = 1 for addiu, andi, ori, slti, lw, sw.
- `ALUOp`: sub/beq/bne = 001; slti = 010; ori = 011; and/andi = 100; else 000.
- `RegDst`: add/sub/and = 10; jal = 00; else 01.
- `DBDataSrc` = 1 only for lw.
- `WrRegDSrc` = 0 only for jal.

State-gated outputs (all 0 unless listed):
- `IRWre` = 1 in IF.
- `PCWre` = 1 in the terminal state of each instruction: ID for j/jr/jal/NOP, EXE_BR, MEM for sw, WB_AL, WB_LD.
- `RegWre` = 1 in WB_AL, WB_LD, and in ID for jal.
- `mWR` = 1 in MEM for sw; `mRD` = 1 in MEM for lw.
- `PCSrc` in PCWre cycles:
  - j/jal: 11; jr: 10
  - beq: 01 when `zero` = 1; bne: 01 when `zero` = 0
  - otherwise 00.
  - 00 in all non-PCWre cycles.

## Timing
- All outputs are combinational from the registered state plus `op` and `zero`; no output register.
- Reset: state = IF. Outputs then take IF values: `IRWre` = 1, all enables 0, `PCSrc` = 00.
- Cycles per instruction:
  - j/jr/jal/NOP: 2
  - beq/bne: 3
  - ALU ops: 4
  - sw: 4
  - lw: 5
- Exactly one `PCWre` pulse per instruction; `RegWre` is never asserted in the same cycle as `mWR`.
- `Reset` asserted in any state, including HLT or mid-instruction, returns to IF on the next edge. Reset has priority over every transition.
- `zero` is sampled only in EXE_BR; changes in other states have no effect.

## Configuration
- `CU_HALT_EN` defined:
  - op 111111 enters HLT from ID.
  - HLT holds with every enable 0 (including `PCWre` and `IRWre`) until `Reset`.
- `CU_HALT_EN` undefined:
  - 111111 is an unknown opcode, so ID → IF with `PCWre` = 1 (NOP).
  - HLT is unreachable.

## Test plan
- Reset, then op = addiu: states IF, ID, EXE_AL, WB_AL, IF. Check `ExtSel` = 1, `ALUSrcB` = 1, `RegDst` = 01, `RegWre` = 1 only in WB_AL, `PCWre` = 1 only in WB_AL.
- op = ori: `ExtSel` = 0 and `ALUOp` = 011 throughout. op = andi: `ExtSel` = 0 and `ALUOp` = 100.
- op = lw: 5 cycles; `mRD` = 1 in MEM; `DBDataSrc` = 1 and `RegWre` = 1 in WB_LD. op = sw: 4 cycles; `mWR` = 1 in MEM; `RegWre` never 1.
- beq with `zero` = 1 gives `PCSrc` = 01; with `zero` = 0 gives 00. bne gives the inverse. `PCWre` = 1 only in EXE_BR.
- jal: in ID, `RegWre` = 1, `RegDst` = 00, `WrRegDSrc` = 0, `PCSrc` = 11, `PCWre` = 1; next state IF.
- halt with `CU_HALT_EN` defined: state stays 1000 for 10 cycles with all enables 0; `Reset` pulse gives state 0000. Without the macro: returns to IF after 2 cycles.
